// File: rtl/hwpe_ctrl_job_sequencer_pkg.sv
// Shared types for the HWPE job sequencer: FSM state encoding, uloop
// control/flag bundles and the top-level wiring structs.
package hwpe_ctrl_job_sequencer_pkg;

  localparam int unsigned SEQ_N_STREAMS = 3;
  localparam int unsigned SEQ_CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD,
    COMPUTE,
    UPDATE,
    WAIT_UL,
    DRAIN,
    DONE
  } seq_state_t;

  // Control towards hwpe_ctrl_uloop
  typedef struct packed {
    logic enable;
    logic clear;
    logic ready;
  } ctrl_uloop_t;

  // Flags coming back from hwpe_ctrl_uloop
  typedef struct packed {
    logic valid;
    logic done;
  } flags_uloop_t;

  // Slave-side job control and status bundles for top-level wiring
  typedef struct packed {
    logic start;
    logic clear;
  } ctrl_seq_t;

  typedef struct packed {
    logic done;
    logic busy;
    logic err;
  } flags_seq_t;

  // A job is active in every state but IDLE (DONE included)
  function automatic logic seq_is_busy(seq_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/hwpe_ctrl_job_sequencer.sv
// Top-level job FSM of the HWPE control plane. Clears the uloop, arms the
// streamers for each tile, waits for engine tile-done, steps the uloop and
// finally drains the streamers before signalling job done to the slave.
module hwpe_ctrl_job_sequencer
  import hwpe_ctrl_job_sequencer_pkg::*;
#(
  parameter int unsigned N_STREAMS = SEQ_N_STREAMS,
  parameter int unsigned CNT_WIDTH = SEQ_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [N_STREAMS-1:0] stream_ready_i,
  input  logic [N_STREAMS-1:0] stream_idle_i,
  output logic [N_STREAMS-1:0] stream_start_o,
  input  logic                 engine_done_i,
  output ctrl_uloop_t          ctrl_uloop_o,
  input  flags_uloop_t         flags_uloop_i,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] tile_cnt_o,
  output logic [CNT_WIDTH-1:0] busy_cycles_o
);

  seq_state_t           state_q, state_d;
  ctrl_uloop_t          ctrl_uloop_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 err_q;
  logic [CNT_WIDTH-1:0] tile_cnt_q;
  logic [CNT_WIDTH-1:0] busy_cycles_q;

  logic all_ready;
  logic all_idle;
  logic job_start;

  assign all_ready = &stream_ready_i;
  assign all_idle  = &stream_idle_i;
  assign job_start = (state_q == IDLE) && start_i;

  // Next-state decode; a soft clear overrides every transition
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_i)       state_d = INIT;
        INIT:                       state_d = LOAD;
        LOAD:    if (all_ready)     state_d = COMPUTE;
        COMPUTE: if (engine_done_i) state_d = UPDATE;
        UPDATE:                     state_d = WAIT_UL;
        WAIT_UL: begin
          if (flags_uloop_i.valid) begin
            state_d = flags_uloop_i.done ? DRAIN : LOAD;
          end
        end
        DRAIN:   if (all_idle)      state_d = DONE;
        DONE:                       state_d = IDLE;
        default:                    state_d = IDLE;
      endcase
    end
  end

  // State register with Moore outputs registered from the next state, so
  // each output is aligned with the state it belongs to
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ctrl_uloop_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q             <= state_d;
      ctrl_uloop_q.enable <= (state_d == UPDATE) || (state_d == WAIT_UL);
      ctrl_uloop_q.ready  <= (state_d == UPDATE);
      ctrl_uloop_q.clear  <= (state_d == INIT);
      done_q              <= (state_d == DONE);
      busy_q              <= seq_is_busy(state_d);
    end
  end

  // Tile counter (wrapping) and busy-cycle counter (saturating); both are
  // zeroed by a soft clear or by the start of a new job and hold in IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tile_cnt_q    <= '0;
      busy_cycles_q <= '0;
    end else if (clear_i || job_start) begin
      tile_cnt_q    <= '0;
      busy_cycles_q <= '0;
    end else begin
      if ((state_q == COMPUTE) && engine_done_i) begin
        tile_cnt_q <= tile_cnt_q + CNT_WIDTH'(1);
      end
      if (busy_q && (busy_cycles_q != '1)) begin
        busy_cycles_q <= busy_cycles_q + CNT_WIDTH'(1);
      end
    end
  end

  // Sticky error: an engine tile-done arriving outside COMPUTE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clear_i || job_start) begin
      err_q <= 1'b0;
    end else if (engine_done_i && (state_q != COMPUTE)) begin
      err_q <= 1'b1;
    end
  end

  // Tile start is the only Mealy output: it fires in LOAD only once every
  // streamer is ready, so all streamers launch on the same cycle
  assign stream_start_o = {N_STREAMS{(state_q == LOAD) && all_ready}};

  assign ctrl_uloop_o  = ctrl_uloop_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign tile_cnt_o    = tile_cnt_q;
  assign busy_cycles_o = busy_cycles_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_sequencer.sv
// Directed testbench for hwpe_ctrl_job_sequencer.
module tb_hwpe_ctrl_job_sequencer;
  import hwpe_ctrl_job_sequencer_pkg::*;

  localparam int NS        = 3;
  localparam int CW        = 32;
  localparam int ENG_DELAY = 5;

  logic          clk_i;
  logic          rst_ni;
  logic          clear_i;
  logic          start_i;
  logic [NS-1:0] stream_ready_i;
  logic [NS-1:0] stream_idle_i;
  logic [NS-1:0] stream_start_o;
  logic          engine_done_i;
  ctrl_uloop_t   ctrl_uloop_o;
  flags_uloop_t  flags_uloop_i;
  logic          done_o;
  logic          busy_o;
  logic          err_o;
  logic [CW-1:0] tile_cnt_o;
  logic [CW-1:0] busy_cycles_o;

  int n_vec = 0;
  int n_err = 0;

  // job driver results
  int n_start, n_upd, n_done, n_busy, n_partial;
  int drain_len, drain_notbusy;
  bit timeout;

  hwpe_ctrl_job_sequencer #(
    .N_STREAMS(NS),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .stream_ready_i(stream_ready_i),
    .stream_idle_i (stream_idle_i),
    .stream_start_o(stream_start_o),
    .engine_done_i (engine_done_i),
    .ctrl_uloop_o  (ctrl_uloop_o),
    .flags_uloop_i (flags_uloop_i),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .tile_cnt_o    (tile_cnt_o),
    .busy_cycles_o (busy_cycles_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  // Reactive environment: engine answers ENG_DELAY cycles after each tile
  // start, the uloop answers valid one cycle into WAIT_UL and reports done
  // after `tiles` updates, and the streamers stay busy for `drain_hold`
  // cycles of DRAIN. Runs from the current negedge until done_o is seen.
  task automatic drive_job(input int tiles, input int drain_hold, input int max_cyc);
    int cd;
    bit final_sent;
    bit finished;
    n_start = 0; n_upd = 0; n_done = 0; n_busy = 0; n_partial = 0;
    drain_len = 0; drain_notbusy = 0; timeout = 1'b0;
    cd = 0; final_sent = 1'b0; finished = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      stream_ready_i = '1;
      stream_idle_i  = (final_sent && (drain_len + 1) <= drain_hold) ? 3'b110 : 3'b111;
      #1;
      if (busy_o) n_busy++;
      if (final_sent && !done_o) begin
        drain_len++;
        if (!busy_o) drain_notbusy++;
      end
      engine_done_i = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) engine_done_i = 1'b1;
      end
      if (stream_start_o != '0) begin
        n_start++;
        if (stream_start_o != 3'b111) n_partial++;
        cd = ENG_DELAY;
      end
      if (ctrl_uloop_o.enable && ctrl_uloop_o.ready) n_upd++;
      flags_uloop_i.valid = ctrl_uloop_o.enable && !ctrl_uloop_o.ready;
      flags_uloop_i.done  = flags_uloop_i.valid && (n_upd >= tiles);
      if (flags_uloop_i.done) final_sent = 1'b1;
      if (done_o) begin
        n_done++;
        finished = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    engine_done_i = 1'b0;
    flags_uloop_i = '0;
    stream_idle_i = '1;
    if (!finished) timeout = 1'b1;
    $display("job: tiles=%0d starts=%0d updates=%0d dones=%0d busy=%0d drain=%0d",
             tiles, n_start, n_upd, n_done, n_busy, drain_len);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_vec++; if (tile_cnt_o !== '0) begin n_err++; $display("FAIL reset_tile: got %0d want 0", tile_cnt_o); end
    n_vec++; if (ctrl_uloop_o !== 3'b000) begin n_err++; $display("FAIL reset_uloop: got %b want 000", ctrl_uloop_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    n_vec++; if (ctrl_uloop_o.clear !== 1'b1) begin n_err++; $display("FAIL init_clear: got %b want 1", ctrl_uloop_o.clear); end
    @(negedge clk_i);
    #1;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL load_busy: got %b want 1", busy_o); end
    n_vec++; if (ctrl_uloop_o.clear !== 1'b0) begin n_err++; $display("FAIL load_clear: got %b want 0", ctrl_uloop_o.clear); end
    n_vec++; if (busy_cycles_o !== 32'd1) begin n_err++; $display("FAIL load_busycyc: got %0d want 1", busy_cycles_o); end
    #1;
    rst_ni = 1'b0;
    #1;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", busy_o); end
    n_vec++; if (busy_cycles_o !== '0) begin n_err++; $display("FAIL async_busycyc: got %0d want 0", busy_cycles_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    stream_ready_i = '1;
    repeat (2) @(negedge clk_i);
    #1;
    n_vec++; if (stream_start_o !== 3'b000) begin n_err++; $display("FAIL idle_nostart: got %b want 000", stream_start_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_three_tiles();
    stream_ready_i = '1;
    stream_idle_i  = '1;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    drive_job(3, 0, 500);
    @(negedge clk_i);
    #1;
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL t3_timeout: got %b want 0", timeout); end
    n_vec++; if (n_start !== 3) begin n_err++; $display("FAIL t3_starts: got %0d want 3", n_start); end
    n_vec++; if (n_partial !== 0) begin n_err++; $display("FAIL t3_partial: got %0d want 0", n_partial); end
    n_vec++; if (n_upd !== 3) begin n_err++; $display("FAIL t3_updates: got %0d want 3", n_upd); end
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL t3_dones: got %0d want 1", n_done); end
    n_vec++; if (drain_len !== 1) begin n_err++; $display("FAIL t3_drain: got %0d want 1", drain_len); end
    n_vec++; if (tile_cnt_o !== 32'd3) begin n_err++; $display("FAIL t3_tilecnt: got %0d want 3", tile_cnt_o); end
    // INIT + 3*(LOAD + 5*COMPUTE + UPDATE + WAIT_UL) + DRAIN + DONE
    n_vec++; if (busy_cycles_o !== 32'd27) begin n_err++; $display("FAIL t3_busycyc: got %0d want 27", busy_cycles_o); end
    n_vec++; if (n_busy !== 27) begin n_err++; $display("FAIL t3_busyobs: got %0d want 27", n_busy); end
    n_vec++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL t3_idle: got busy=%b done=%b want 0 0", busy_o, done_o); end
  endtask

  task automatic test_ready_gating();
    stream_ready_i = 3'b011;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      #1;
      n_vec++; if (stream_start_o !== 3'b000) begin n_err++; $display("FAIL gate_hold%0d: got %b want 000", k, stream_start_o); end
    end
    #1;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL gate_busy: got %b want 1", busy_o); end
    @(negedge clk_i);
    drive_job(1, 0, 200);
    @(negedge clk_i);
    #1;
    n_vec++; if (n_start !== 1) begin n_err++; $display("FAIL gate_starts: got %0d want 1", n_start); end
    n_vec++; if (n_partial !== 0) begin n_err++; $display("FAIL gate_partial: got %0d want 0", n_partial); end
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL gate_dones: got %0d want 1", n_done); end
    n_vec++; if (tile_cnt_o !== 32'd1) begin n_err++; $display("FAIL gate_tilecnt: got %0d want 1", tile_cnt_o); end
  endtask

  task automatic test_drain_hold();
    stream_ready_i = '1;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    drive_job(1, 7, 200);
    @(negedge clk_i);
    #1;
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL drain_timeout: got %b want 0", timeout); end
    n_vec++; if (drain_len !== 8) begin n_err++; $display("FAIL drain_len: got %0d want 8", drain_len); end
    n_vec++; if (drain_notbusy !== 0) begin n_err++; $display("FAIL drain_busy: got %0d idle cycles want 0", drain_notbusy); end
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL drain_dones: got %0d want 1", n_done); end
    // INIT + LOAD + 5*COMPUTE + UPDATE + WAIT_UL + 8*DRAIN + DONE
    n_vec++; if (busy_cycles_o !== 32'd18) begin n_err++; $display("FAIL drain_busycyc: got %0d want 18", busy_cycles_o); end
  endtask

  task automatic test_err_sticky();
    @(negedge clk_i);
    engine_done_i = 1'b1;
    @(negedge clk_i);
    engine_done_i = 1'b0;
    #1;
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL err_idle: got %b want 1", err_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL err_idle_busy: got %b want 0", busy_o); end
    n_vec++; if (tile_cnt_o !== 32'd1) begin n_err++; $display("FAIL err_idle_tile: got %0d want 1", tile_cnt_o); end
    @(negedge clk_i);
    #1;
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err_o); end
    stream_ready_i = 3'b000;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL err_startclr: got %b want 0", err_o); end
    @(negedge clk_i);
    engine_done_i = 1'b1;
    @(negedge clk_i);
    engine_done_i = 1'b0;
    #1;
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL err_load: got %b want 1", err_o); end
    n_vec++; if (ctrl_uloop_o.enable !== 1'b0) begin n_err++; $display("FAIL err_load_uloop: got %b want 0", ctrl_uloop_o.enable); end
    drive_job(1, 0, 200);
    @(negedge clk_i);
    #1;
    n_vec++; if (n_start !== 1 || n_done !== 1) begin n_err++; $display("FAIL err_job: got starts=%0d dones=%0d want 1 1", n_start, n_done); end
    n_vec++; if (tile_cnt_o !== 32'd1) begin n_err++; $display("FAIL err_job_tile: got %0d want 1", tile_cnt_o); end
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL err_hold: got %b want 1", err_o); end
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL err_restart: got %b want 0", err_o); end
    n_vec++; if (tile_cnt_o !== '0) begin n_err++; $display("FAIL err_restart_tile: got %0d want 0", tile_cnt_o); end
    n_vec++; if (busy_cycles_o !== '0) begin n_err++; $display("FAIL err_restart_cyc: got %0d want 0", busy_cycles_o); end
    drive_job(2, 0, 300);
    @(negedge clk_i);
    #1;
    n_vec++; if (tile_cnt_o !== 32'd2) begin n_err++; $display("FAIL err_job2_tile: got %0d want 2", tile_cnt_o); end
  endtask

  task automatic test_clear_and_start_ignore();
    int dones;
    stream_ready_i = '1;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    clear_i       = 1'b1;
    engine_done_i = 1'b1;
    @(negedge clk_i);
    clear_i       = 1'b0;
    engine_done_i = 1'b0;
    #1;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b want 0", busy_o); end
    n_vec++; if (tile_cnt_o !== '0) begin n_err++; $display("FAIL clr_tile: got %0d want 0", tile_cnt_o); end
    n_vec++; if (busy_cycles_o !== '0) begin n_err++; $display("FAIL clr_busycyc: got %0d want 0", busy_cycles_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL clr_err: got %b want 0", err_o); end
    n_vec++; if (ctrl_uloop_o !== 3'b000) begin n_err++; $display("FAIL clr_uloop: got %b want 000", ctrl_uloop_o); end
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      if (done_o || busy_o) dones++;
      @(negedge clk_i);
      #1;
    end
    n_vec++; if (dones !== 0) begin n_err++; $display("FAIL clr_quiet: got %0d active cycles want 0", dones); end
    start_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    drive_job(2, 0, 300);
    n_vec++; if (n_done !== 1 || n_start !== 2) begin n_err++; $display("FAIL busystart_job: got dones=%0d starts=%0d want 1 2", n_done, n_start); end
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      #1;
      if (done_o || busy_o) dones++;
    end
    n_vec++; if (dones !== 0) begin n_err++; $display("FAIL busystart_queued: got %0d active cycles want 0", dones); end
    n_vec++; if (tile_cnt_o !== 32'd2) begin n_err++; $display("FAIL busystart_tile: got %0d want 2", tile_cnt_o); end
  endtask

  initial begin
    rst_ni         = 1'b0;
    clear_i        = 1'b0;
    start_i        = 1'b0;
    stream_ready_i = '0;
    stream_idle_i  = '1;
    engine_done_i  = 1'b0;
    flags_uloop_i  = '0;
    test_reset();
    test_three_tiles();
    test_ready_gating();
    test_drain_hold();
    test_err_sticky();
    test_clear_and_start_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
